// File: rtl/rom_dl_router_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_dl_router_if
// Description : Bundle of the hps_io ioctl signals, the per-port address
//               windows, the SDRAM write-port toggle handshakes, the DIP
//               switch bank and the sticky error flags of rom_dl_router.
//               master : the surrounding system (hps_io, SDRAM ports, config)
//               slave  : the router itself
// Revision    : 1.0 - initial release
// ============================================================================
interface rom_dl_router_if #(
  parameter int NUM_PORTS = 2
);
  // hps_io download side
  logic                      ioctl_download;
  logic                      ioctl_wr;
  logic [24:0]               ioctl_addr;
  logic [7:0]                ioctl_dout;
  logic [7:0]                ioctl_index;
  logic                      ioctl_wait;
  // per-port address windows, 25 bits per port, inclusive bounds
  logic [NUM_PORTS*25-1:0]   region_base;
  logic [NUM_PORTS*25-1:0]   region_end;
  // SDRAM write ports (toggle handshake)
  logic [NUM_PORTS-1:0]      port_req;
  logic [NUM_PORTS-1:0]      port_ack;
  logic [NUM_PORTS*24-1:0]   port_a;
  logic [NUM_PORTS*2-1:0]    port_ds;
  logic [NUM_PORTS*16-1:0]   port_d;
  // DIP switch bytes and sticky status
  logic [63:0]               dip_sw;
  logic                      err_timeout;
  logic                      err_overrun;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output region_base, region_end, port_ack,
    input  ioctl_wait, port_req, port_a, port_ds, port_d,
    input  dip_sw, err_timeout, err_overrun
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  region_base, region_end, port_ack,
    output ioctl_wait, port_req, port_a, port_ds, port_d,
    output dip_sw, err_timeout, err_overrun
  );
endinterface
`default_nettype wire

// File: rtl/rom_dl_router.sv
`default_nettype none
// ============================================================================
// Module      : rom_dl_router
// Description : ROM-download dispatcher from hps_io ioctl writes to up to
//               four SDRAM write ports. Each port owns an inclusive address
//               window with its own base; a byte landing in a window is
//               presented as a 16-bit word write (address relative to the
//               window base, one-hot byte lane) and the port's toggle
//               request flips. Writes to DIP_INDEX at addresses 0..7 are
//               captured into the 64-bit dip_sw bank.
//
//               Optional feature macro: DL_ROUTER_WAIT_EN
//                 defined   : ack-wait FSM, ioctl_wait backpressure, ack
//                             timeout counter, sticky err_timeout and
//                             err_overrun flags.
//                 undefined : fire-and-forget; every ROM write toggles,
//                             port_ack ignored, ioctl_wait and both error
//                             flags tied low.
//
// Ports       : clk_sys - single clock, rising edge
//               reset   - asynchronous, active-high, clears all state
//               bus     - rom_dl_router_if.slave (ioctl in / wait out,
//                         windows, port req/ack/a/ds/d, dip_sw, errors)
// Revision    : 1.0 - initial release
// ============================================================================
module rom_dl_router #(
  parameter int          NUM_PORTS   = 2,    // 1..4
  parameter int unsigned ROM_INDEX   = 0,
  parameter int unsigned DIP_INDEX   = 254,
  parameter int unsigned ACK_TIMEOUT = 255   // 1..65535
) (
  input  wire logic      clk_sys,
  input  wire logic      reset,
  rom_dl_router_if.slave bus
);

  localparam logic [7:0] C_ROM_IDX = 8'(ROM_INDEX);
  localparam logic [7:0] C_DIP_IDX = 8'(DIP_INDEX);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic                    wr_last_q,  wr_last_d;
  logic [NUM_PORTS-1:0]    port_req_q, port_req_d;
  logic [NUM_PORTS*24-1:0] port_a_q,   port_a_d;
  logic [NUM_PORTS*2-1:0]  port_ds_q,  port_ds_d;
  logic [NUM_PORTS*16-1:0] port_d_q,   port_d_d;
  logic [63:0]             dip_sw_q,   dip_sw_d;

  // --------------------------------------------------------------------------
  // Event decode
  // --------------------------------------------------------------------------
  logic                 wr_event;
  logic                 rom_event;
  logic                 dip_event;
  logic [NUM_PORTS-1:0] hit;
  logic                 issue;      // launch a write to every hit port

  assign wr_event  = bus.ioctl_wr & ~wr_last_q;
  assign rom_event = wr_event & bus.ioctl_download & (bus.ioctl_index == C_ROM_IDX);
  // DIP bytes arrive regardless of the download level
  assign dip_event = wr_event & (bus.ioctl_index == C_DIP_IDX) &
                     (bus.ioctl_addr[24:3] == 22'd0);

  // Inclusive unsigned window compare over the full 25 bits, so a window
  // ending at 25'h1FFFFFF matches its last byte without wrapping.
  always_comb begin
    hit = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      hit[p] = (bus.ioctl_addr >= bus.region_base[p*25 +: 25]) &&
               (bus.ioctl_addr <= bus.region_end[p*25 +: 25]);
    end
  end

`ifdef DL_ROUTER_WAIT_EN
  // --------------------------------------------------------------------------
  // Ack-wait FSM
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

  localparam logic [15:0] C_TMO = 16'(ACK_TIMEOUT);

  state_t               state_q, state_d;
  logic [15:0]          tmo_cnt_q, tmo_cnt_d;
  logic [NUM_PORTS-1:0] pend_q, pend_d;      // ports launched by the last write
  logic                 dl_last_q, dl_last_d;
  logic                 err_timeout_q, err_timeout_d;
  logic                 err_overrun_q, err_overrun_d;
  logic                 dl_rise;
  logic                 all_acked;
  logic [15:0]          tmo_cnt_inc;

  assign dl_rise     = bus.ioctl_download & ~dl_last_q;
  // Only ports that took part in the current write need a matching ack;
  // ports left hanging by an earlier timeout do not block later writes.
  assign all_acked   = &(~pend_q | ~(bus.port_ack ^ port_req_q));
  assign tmo_cnt_inc = tmo_cnt_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    pend_d    = pend_q;
    dl_last_d = bus.ioctl_download;
    issue     = 1'b0;
    // A new download session starts with clean flags; a flag raised on the
    // same edge still wins below.
    err_timeout_d = dl_rise ? 1'b0 : err_timeout_q;
    err_overrun_d = dl_rise ? 1'b0 : err_overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (rom_event && (hit != '0)) begin
          issue     = 1'b1;
          pend_d    = hit;
          tmo_cnt_d = 16'd0;
          state_d   = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // A ROM write while busy is dropped and flagged
        if (rom_event) begin
          err_overrun_d = 1'b1;
        end
        tmo_cnt_d = tmo_cnt_inc;
        // Ack wins over a timeout reached on the same edge
        if (all_acked) begin
          state_d = ST_IDLE;
        end else if (tmo_cnt_inc == C_TMO) begin
          state_d       = ST_IDLE;
          err_timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      tmo_cnt_q     <= 16'd0;
      pend_q        <= '0;
      dl_last_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_cnt_q     <= tmo_cnt_d;
      pend_q        <= pend_d;
      dl_last_q     <= dl_last_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign bus.ioctl_wait  = (state_q == ST_WAIT_ACK);
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_overrun = err_overrun_q;
`else
  // --------------------------------------------------------------------------
  // Fire-and-forget: every ROM write with at least one hit is launched
  // --------------------------------------------------------------------------
  logic            unused_ack;
  localparam int unsigned unused_ack_timeout = ACK_TIMEOUT;

  assign unused_ack      = ^bus.port_ack;
  assign issue           = rom_event & (hit != '0);
  assign bus.ioctl_wait  = 1'b0;
  assign bus.err_timeout = 1'b0;
  assign bus.err_overrun = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Port datapath and DIP capture
  // --------------------------------------------------------------------------
  always_comb begin
    logic [24:0] off_v;
    wr_last_d  = bus.ioctl_wr;
    port_req_d = port_req_q;
    port_a_d   = port_a_q;
    port_ds_d  = port_ds_q;
    port_d_d   = port_d_q;
    dip_sw_d   = dip_sw_q;
    off_v      = 25'd0;

    if (issue) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (hit[p]) begin
          off_v               = bus.ioctl_addr - bus.region_base[p*25 +: 25];
          port_a_d[p*24 +: 24] = off_v[24:1];
          // Odd byte goes to the upper lane
          port_ds_d[p*2 +: 2]  = {off_v[0], ~off_v[0]};
          port_d_d[p*16 +: 16] = {bus.ioctl_dout, bus.ioctl_dout};
          port_req_d[p]        = ~port_req_q[p];
        end
      end
    end

    if (dip_event) begin
      dip_sw_d[{bus.ioctl_addr[2:0], 3'b000} +: 8] = bus.ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_last_q  <= 1'b0;
      port_req_q <= '0;
      port_a_q   <= '0;
      port_ds_q  <= '0;
      port_d_q   <= '0;
      dip_sw_q   <= 64'd0;
    end else begin
      wr_last_q  <= wr_last_d;
      port_req_q <= port_req_d;
      port_a_q   <= port_a_d;
      port_ds_q  <= port_ds_d;
      port_d_q   <= port_d_d;
      dip_sw_q   <= dip_sw_d;
    end
  end

  assign bus.port_req = port_req_q;
  assign bus.port_a   = port_a_q;
  assign bus.port_ds  = port_ds_q;
  assign bus.port_d   = port_d_q;
  assign bus.dip_sw   = dip_sw_q;

endmodule
`default_nettype wire

// File: doc/rom_dl_router.md
# rom_dl_router

Parametrised ROM-download dispatcher between `hps_io` ioctl signals and up to four SDRAM write ports. It generalises the current fixed two-port toggle controller in four ways:
- per-port address windows, each with its own base offset;
- an optional ack-wait handshake with `ioctl_wait` backpressure;
- an ack timeout with sticky error flags;
- integrated DIP-switch capture.

It sits in the `emu` top, on the SDRAM clock domain, beside the `sdram` instance.

## Interface
- `NUM_PORTS`, 2: number of SDRAM write ports, 1..4.
- `ROM_INDEX`, 0: `ioctl_index` value routed to ports.
- `DIP_INDEX`, 254: `ioctl_index` value captured into `dip_sw`.
- `ACK_TIMEOUT`, 255: cycles to wait for acks before forcing completion, 1..65535.

Ports:
- `clk_sys`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `ioctl_download`  in  1  download active.
- `ioctl_wr`  in  1  byte strobe, level; rising edge is a write.
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  byte data.
- `ioctl_index`  in  8  download index.
- `ioctl_wait`  out  1  backpressure to `hps_io`.
- `region_base`  in  NUM_PORTS*25  per-port window start, inclusive.
- `region_end`  in  NUM_PORTS*25  per-port window end, inclusive.
- `port_req`  out  NUM_PORTS  toggle request, one per port.
- `port_ack`  in  NUM_PORTS  toggle ack; done when equal to `port_req`.
- `port_a`  out  NUM_PORTS*24  word address = (addr − base)[24:1].
- `port_ds`  out  NUM_PORTS*2  byte lane {off[0], ~off[0]}.
- `port_d`  out  NUM_PORTS*16  {dout, dout}.
- `dip_sw`  out  64  DIP bytes; byte k sits at bits [8k+7:8k].
- `err_timeout`  out  1  sticky; an ack timeout occurred.
- `err_overrun`  out  1  sticky; a write edge arrived while busy.

## Operation
- Edge detect: `wr_last` holds the previous `ioctl_wr`. A write event is `ioctl_wr & ~wr_last`.
- ROM write: a write event with `ioctl_download` high and `ioctl_index == ROM_INDEX`.
- Hit vector: bit p is set when `region_base[p] <= ioctl_addr <= region_end[p]`, compared unsigned over 25 bits.
- Multiple hits broadcast the same byte to every hit port. With zero hits the write is discarded; state stays IDLE and no request is issued.
- For each hit port, on the event edge: `port_a`, `port_ds` and `port_d` are registered, then `port_req[p]` toggles. Non-hit ports keep their outputs unchanged.
- FSM, with macro: IDLE → WAIT_ACK on an event with a nonzero hit vector. WAIT_ACK → IDLE when every pending port has `port_ack == port_req`, or when the timeout counter reaches `ACK_TIMEOUT`. On timeout, `err_timeout` is set to 1.
- `ioctl_wait` = (state == WAIT_ACK).
- Write event in WAIT_ACK: the event is dropped, `err_overrun` is set to 1, and no toggle occurs.
- DIP write: a write event with `ioctl_index == DIP_INDEX` and `ioctl_addr[24:3] == 0` stores `ioctl_dout` into byte `ioctl_addr[2:0]` of `dip_sw`. The `ioctl_download` level is not required. DIP writes never enter WAIT_ACK.
- Error flags clear only on `reset` or on a rising edge of `ioctl_download`.

## Timing
- Reset values: `port_req`=0, `port_a`=0, `port_ds`=0, `port_d`=0, `ioctl_wait`=0, `dip_sw`=0, both error flags=0, FSM=IDLE, `wr_last`=0, timeout counter=0.
- Outputs and `port_req` toggles appear at the first clock edge on which `ioctl_wr` is sampled high, i.e. one register stage.
- `ioctl_wait` rises on that same edge.
- `ioctl_wait` falls on the edge after the last matching ack is sampled, giving a minimum WAIT_ACK of 1 cycle.
- The timeout counter clears on entry to WAIT_ACK and increments every cycle in WAIT_ACK. The timeout exit happens on the edge where the counter equals `ACK_TIMEOUT`.
- An ack arriving on the same edge as the timeout is treated as success; `err_timeout` is not set.
- A `reset` assertion mid-handshake forces IDLE immediately (asynchronous). The pending byte is lost.
- A fall of `ioctl_download` while in WAIT_ACK does not abort; the FSM completes normally.
- Window ends at 25'h1FFFFFF must match without wrap-around.

## Configuration
- `DL_ROUTER_WAIT_EN` defined: the full FSM, `ioctl_wait`, the timeout counter and `err_timeout`/`err_overrun` are built.
- `DL_ROUTER_WAIT_EN` not defined: fire-and-forget behaviour.
  - Toggles occur on every ROM write event.
  - `port_ack` is ignored, `ioctl_wait` is tied to 0, and both error flags are tied to 0.
  - Back-to-back events toggle on consecutive edges.

## Test plan
- Single-port write: NUM_PORTS=2; region 0 = 0x00000–0x0FFFF, region 1 = 0x10000–0x1BFFF. Write addr 0x00003, data 0xA5 → `port_req[0]` toggles; `port_a[0]`=0x000001, `port_ds[0]`=2'b10, `port_d[0]`=0xA5A5; port 1 is unchanged.
- Offset write: same regions, write addr 0x10000 → `port_a[1]`=0, `port_ds[1]`=2'b01. Ack after 3 cycles → `ioctl_wait` is high for exactly 4 cycles.
- Overlap broadcast: both windows = 0x0–0xFFFF → both reqs toggle on the same edge. Acking port 0 only, with `ACK_TIMEOUT`=10 → exit after 10 cycles and `err_timeout`=1.
- Overrun: a second `ioctl_wr` edge while in WAIT_ACK → no extra toggle and `err_overrun`=1. A new `ioctl_download` rising edge clears the flag to 0.
- DIP capture: index 254; write addr 1 = 0x3C and addr 8 = 0xFF → `dip_sw[15:8]`=0x3C, and all other bytes stay 0.
- Reset in WAIT_ACK: assert `reset` → `ioctl_wait`=0 and `port_req`=0 asynchronously, without waiting for a clock edge.
